conv_window_3x3: RTL and testbench

CONV_WINDOW_3X3 -- requirements
Module: conv_window_3x3

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_line_buf.sv | 34 +++
 rtl/conv_window_3x3.sv | 119 +++++++++++
 tb/tb_conv_window_3x3.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution window generator.
// Contents: FSM state encoding (FILL/RUN), window slice index constants,
// and a helper mapping (row, col) of the window to its slice index.
package conv_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slice k = 3*r + c of the packed window; r=0 is the oldest row, c=0 the oldest column.
    localparam int K00 = 0;
    localparam int K01 = 1;
    localparam int K02 = 2;
    localparam int K10 = 3;
    localparam int K11 = 4;
    localparam int K12 = 5;
    localparam int K20 = 6;
    localparam int K21 = 7;
    localparam int K22 = 8;

    function automatic int slice_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: fixed-length pixel delay line of DEPTH accepted pixels.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-low reset (clears the whole line)
//   ce    - clock enable; low freezes contents
//   shift - advance the line by one pixel (when ce=1)
//   din   - pixel entering the line
//   dout  - pixel that entered DEPTH shifts ago
module conv_line_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst)
            mem <= '0;
        else if (ce && shift)
            mem <= {mem[DEPTH-2:0], din};
    end

    // The oldest entry is exactly DEPTH shifts old, so it is read combinationally
    // and lines up with the pixel being accepted now.
    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: streams raster-order pixels and emits every 3x3 window that
// lies fully inside the IMG_W x IMG_H frame.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-low reset (priority over ce)
//   ce         - clock enable; low freezes all state, win_vld/frame_done read 0
//   din_vld    - pixel valid; a pixel is accepted when din_vld=1 and ce=1
//   din        - raster-order pixel, row 0 first
//   win        - 3x3 window, slice k=3*r+c at [WIDTH*(k+1)-1:WIDTH*k]
//   win_vld    - one-cycle pulse per valid window
//   frame_done - one-cycle pulse after the last pixel of a frame is accepted
module conv_window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               din_vld,
    input  logic [WIDTH-1:0]   din,
    output logic [9*WIDTH-1:0] win,
    output logic               win_vld,
    output logic               frame_done
);

    import conv_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    state_t        state, state_nxt;
    logic          acc, col_last, row_last, frame_last, win_hit;
    logic          vld_q, fd_q;
    logic [WIDTH-1:0] lb1_out, lb2_out;
    logic [2:0][2:0][WIDTH-1:0] w, w_nxt;
    logic [9*WIDTH-1:0] win_nxt;

    assign acc        = ce & din_vld;
    assign col_last   = col == CW'(IMG_W - 1);
    assign row_last   = row == RW'(IMG_H - 1);
    assign frame_last = col_last & row_last;
    // RUN is exactly "row >= 2"; col >= 2 keeps windows from straddling rows.
    assign win_hit    = acc && state == RUN && col >= CW'(2);

    conv_line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .shift (din_vld),
        .din   (din),
        .dout  (lb1_out)
    );

    conv_line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .shift (din_vld),
        .din   (lb1_out),
        .dout  (lb2_out)
    );

    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (state == FILL && row == RW'(1) && col_last)
                state_nxt = RUN;
            else if (state == RUN && frame_last)
                state_nxt = FILL;
        end
    end

    always_comb begin
        w_nxt = w;
        for (int r = 0; r < 3; r++) begin
            w_nxt[r][0] = w[r][1];
            w_nxt[r][1] = w[r][2];
        end
        w_nxt[0][2] = lb2_out;
        w_nxt[1][2] = lb1_out;
        w_nxt[2][2] = din;
        win_nxt = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_nxt[WIDTH*slice_idx(r, c) +: WIDTH] = w_nxt[r][c];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
            w     <= '0;
            win   <= '0;
            vld_q <= 1'b0;
            fd_q  <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            vld_q <= win_hit;
            fd_q  <= acc & frame_last;
            if (acc) begin
                w   <= w_nxt;
                col <= col_last ? '0 : col + CW'(1);
                if (col_last)
                    row <= row_last ? '0 : row + RW'(1);
            end
            if (win_hit)
                win <= win_nxt;
        end
    end

    // Pulses are held pending in frozen state while ce=0 and only shown once ce is high.
    assign win_vld    = vld_q & ce;
    assign frame_done = fd_q & ce;

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb_conv_window_3x3: directed bench for conv_window_3x3 with a frame-image reference model.
module tb_conv_window_3x3;

    import conv_pkg::*;

    localparam int WIDTH = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int WW = 9 * WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          din_vld = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WW-1:0] win;
    logic          win_vld;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    conv_window_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din_vld    (din_vld),
        .din        (din),
        .win        (win),
        .win_vld    (win_vld),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
        int v[9];
        logic [WW-1:0] p;
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        p = '0;
        for (int k = 0; k < 9; k++)
            p[k*WIDTH +: WIDTH] = WIDTH'(v[k]);
        return p;
    endfunction

    // Reference model: stores the current frame as a 2-D image and, whenever a
    // pixel at (r,c) with r>=2,c>=2 is accepted, reads the 3x3 neighbourhood ending there.
    logic [WIDTH-1:0] img [IMG_H][IMG_W];
    int            mr = 0, mc = 0;
    logic          m_vq = 1'b0, m_fq = 1'b0;
    logic [WW-1:0] m_win = '0;

    always @(posedge clk) begin
        if (!rst) begin
            mr = 0; mc = 0; m_vq = 1'b0; m_fq = 1'b0; m_win = '0;
        end else if (ce) begin
            m_vq = 1'b0;
            m_fq = 1'b0;
            if (din_vld) begin
                img[mr][mc] = din;
                if (mr >= 2 && mc >= 2) begin
                    m_vq = 1'b1;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            m_win[(3*i+j)*WIDTH +: WIDTH] = img[mr-2+i][mc-2+j];
                end
                if (mr == IMG_H - 1 && mc == IMG_W - 1)
                    m_fq = 1'b1;
                if (mc == IMG_W - 1) begin
                    mc = 0;
                    mr = (mr == IMG_H - 1) ? 0 : mr + 1;
                end else
                    mc++;
            end
        end
    end

    logic [WW-1:0] wq[$];
    int nfd = 0;

    always @(negedge clk) begin
        chk("win_vld", WW'(win_vld), WW'(m_vq & ce));
        chk("frame_done", WW'(frame_done), WW'(m_fq & ce));
        chk("win", win, m_win);
        if (win_vld) wq.push_back(win);
        if (frame_done) nfd++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        step();
        ce = 1'b1; din_vld = 1'b1; din = WIDTH'(v);
        for (int g = 0; g < gap; g++) begin
            step();
            din_vld = 1'b0; din = 8'hEE;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            din_vld = 1'b0;
        end
    endtask

    task automatic clear_log();
        wq.delete();
        nfd = 0;
    endtask

    task automatic frame(input int base, input int gap);
        for (int p = 0; p < IMG_W * IMG_H; p++) send(base + p, gap);
    endtask

    task automatic chk_frame(input string tag, input int nexp);
        chk({tag, "_count"}, WW'(wq.size()), WW'(nexp));
        if (wq.size() >= 9) begin
            chk({tag, "_first"}, wq[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            chk({tag, "_last"}, wq[8], pack9(12, 13, 14, 17, 18, 19, 22, 23, 24));
        end
    endtask

    logic [WW-1:0] first_w;

    initial begin
        step(); step();
        #3;
        chk("rst_win", win, '0);
        chk("rst_vld", WW'(win_vld), '0);
        chk("rst_fd", WW'(frame_done), '0);
        step();
        rst = 1'b1;

        // continuous frame
        clear_log();
        frame(0, 0);
        idle(2);
        chk_frame("cont", 9);
        chk("cont_fd", WW'(nfd), WW'(1));
        if (wq.size() > 0) begin
            first_w = wq[0];
            chk("cont_k22", WW'(first_w[K22*WIDTH +: WIDTH]), WW'(12));
            chk("cont_k00", WW'(first_w[K00*WIDTH +: WIDTH]), WW'(0));
        end

        // 3 idle cycles after every pixel
        clear_log();
        frame(0, 3);
        idle(2);
        chk_frame("gap", 9);
        chk("gap_fd", WW'(nfd), WW'(1));

        // ce low for 4 cycles after pixel 12
        clear_log();
        for (int p = 0; p <= 12; p++) send(p, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            ce = 1'b0; din_vld = 1'b1; din = 8'h63;
            #3;
            chk("ce_low_vld", WW'(win_vld), '0);
        end
        step();
        ce = 1'b1; din_vld = 1'b1; din = 8'd13;
        #3;
        chk("ce_back_vld", WW'(win_vld), WW'(1));
        chk("ce_back_win", win, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        for (int p = 14; p < 25; p++) send(p, 0);
        idle(2);
        chk_frame("ce", 9);
        chk("ce_fd", WW'(nfd), WW'(1));

        // reset after pixel 17, then a full frame
        for (int p = 0; p <= 17; p++) send(p, 0);
        step();
        din_vld = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1;
        #3;
        chk("mid_rst_win", win, '0);
        clear_log();
        frame(0, 0);
        idle(2);
        chk_frame("rst", 9);
        chk("rst_fd_cnt", WW'(nfd), WW'(1));

        // two back-to-back frames
        clear_log();
        frame(0, 0);
        frame(100, 0);
        idle(2);
        chk_frame("b2b", 18);
        chk("b2b_fd", WW'(nfd), WW'(2));
        if (wq.size() >= 18) begin
            chk("b2b_f2_first", wq[9], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
            chk("b2b_f2_last", wq[17], pack9(112, 113, 114, 117, 118, 119, 122, 123, 124));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
